// File: rtl/int_div_ctrl.sv
// Request/response controller around the multi-cycle unsigned divider core.
// Resolves divide-by-zero and signed overflow locally and applies the quotient sign correction.
module int_div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             signed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quot_o,
  output logic             dz_o,
  output logic             ovf_o,
  output logic             core_start_o,
  output logic [WIDTH-1:0] core_n_o,
  output logic [WIDTH-1:0] core_d_o,
  input  logic [WIDTH-1:0] core_q_i,
  input  logic             core_valid_i
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic             neg_res;

  logic             div_zero;
  logic             sgn_ovf;
  logic             neg_in;
  logic [WIDTH-1:0] n_mag;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH-1:0] q_fix;

  // Negating MIN leaves MIN, which the core correctly reads as 2^(WIDTH-1).
  always_comb begin
    div_zero = (divisor_i == '0);
    sgn_ovf  = signed_i && (dividend_i == MIN_VAL) && (divisor_i == '1);
    neg_in   = signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
    n_mag    = (signed_i && dividend_i[WIDTH-1]) ? (~dividend_i + 1'b1) : dividend_i;
    d_mag    = (signed_i && divisor_i[WIDTH-1])  ? (~divisor_i + 1'b1)  : divisor_i;
    q_fix    = neg_res ? (~core_q_i + 1'b1) : core_q_i;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state        <= IDLE;
      in_ready_o   <= 1'b1;
      out_valid_o  <= 1'b0;
      quot_o       <= '0;
      dz_o         <= 1'b0;
      ovf_o        <= 1'b0;
      core_start_o <= 1'b0;
      core_n_o     <= '0;
      core_d_o     <= '0;
      neg_res      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            in_ready_o <= 1'b0;
            core_n_o   <= n_mag;
            core_d_o   <= d_mag;
            neg_res    <= neg_in;
            if (div_zero) begin
              quot_o      <= '1;
              dz_o        <= 1'b1;
              ovf_o       <= 1'b0;
              out_valid_o <= 1'b1;
              state       <= RESP;
            end else if (sgn_ovf) begin
              quot_o      <= MIN_VAL;
              dz_o        <= 1'b0;
              ovf_o       <= 1'b1;
              out_valid_o <= 1'b1;
              state       <= RESP;
            end else begin
              core_start_o <= 1'b1;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          core_start_o <= 1'b0;
          state        <= WAIT;
        end
        WAIT: begin
          if (core_valid_i) begin
            quot_o      <= q_fix;
            dz_o        <= 1'b0;
            ovf_o       <= 1'b0;
            out_valid_o <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          in_ready_o   <= 1'b1;
          out_valid_o  <= 1'b0;
          core_start_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
